frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
- Frame-level controller that sequences the pixel-processing core.
- Starts one processing pass per completed camera frame and gates the core's pixel enable for exactly one frame.
- Optionally hands the finished frame to the LeNet engine, then ping-pongs the double-buffered output memory banks in step with VGA vsync.
- Sits between the camera capture, the processing core, the LeNet block and the VGA scanout.

Parameters:
- WIDTH, 640: pixels per line.
- HEIGHT, 480: lines per frame.
- LENET_TIMEOUT, 1048576: maximum cycles to wait for lenet_done before aborting.
- C_FRAME: localparam = WIDTH*HEIGHT.

Ports:
- clk25  in  1  pixel clock; only clock.
- rst  in  1  synchronous, active-high reset.
- cam_vsync  in  1  camera frame-complete level, synchronous to clk25; a rising edge means a frame is ready in mem0.
- vga_vsync  in  1  VGA frame-boundary level, synchronous to clk25; a rising edge is a safe bank-swap point.
- lenet_signal  in  1  request: run LeNet on the next processed frame.
- lenet_done  in  1  one-cycle pulse from LeNet at completion.
- core_en  out  1  pixel enable to the core; high exactly C_FRAME cycles per pass.
- core_pix_cnt  out  19  index of the current pixel, 0..C_FRAME-1.
- wr_bank  out  1  output-buffer bank the core writes.
- rd_bank  out  1  output-buffer bank VGA reads; always ~wr_bank.
- lenet_start  out  1  one-cycle start pulse to LeNet.
- lenet_busy  out  1  high while waiting on LeNet.
- frame_cnt  out  8  completed-swap counter; wraps 255->0.
- timeout_err  out  1  sticky; set on LeNet timeout.

Behaviour:
- Reset (synchronous, active-high), all outputs and internal state:
  - core_en=0, core_pix_cnt=0, wr_bank=0, rd_bank=1, lenet_start=0, lenet_busy=0, frame_cnt=0, timeout_err=0.
  - FSM=IDLE; cam_pend=0, lenet_req=0; both edge-detect registers cleared.
  - Asserting rst mid-pass aborts the pass; nothing is preserved.
- Edge detect: previous vsync levels are registered; rise = cur & ~prev.
- Request latching:
  - lenet_req is sticky and set by lenet_signal in any state.
  - It is cleared on entry to LENET.
  - If set and cleared in the same cycle, the set wins (the request applies to the following frame).
- Camera-frame latching:
  - cam_pend is set by a cam_vsync rise in any state other than IDLE.
  - It holds at most one frame; further rises while it is set are dropped.
- IDLE:
  - On a cam_vsync rise, or cam_pend=1: go to PROCESS and clear cam_pend.
  - core_en goes 1 in the first PROCESS cycle (one-cycle latency from the rise).
- PROCESS:
  - core_en=1 for exactly C_FRAME consecutive cycles.
  - core_pix_cnt increments each cycle from 0.
  - At core_pix_cnt==C_FRAME-1 (the last enabled cycle): if lenet_req, go to LENET, else go to SWAP_WAIT.
  - core_pix_cnt returns to 0 on exit.
- LENET:
  - lenet_start=1 in the first LENET cycle only; lenet_busy=1 throughout.
  - A 20-bit timeout counter starts at 0 on entry.
  - lenet_done=1: go to SWAP_WAIT.
  - Counter==LENET_TIMEOUT-1 without done: set timeout_err, go to SWAP_WAIT.
  - If lenet_done and timeout coincide, done wins and timeout_err is not set.
  - lenet_done outside LENET is ignored.
- SWAP_WAIT:
  - On a vga_vsync rise: wr_bank<=~wr_bank, rd_bank<=wr_bank, frame_cnt<=frame_cnt+1, go to IDLE.
  - A cam_vsync rise in the swap cycle sets cam_pend, so IDLE starts the next pass one cycle later.
- Invariant: rd_bank == ~wr_bank in every cycle.
- Width and arithmetic:
  - Counters are unsigned and wrap naturally.
  - core_pix_cnt must hold C_FRAME-1 (19 bits for 640x480).

Decomposition:
- Shared package cv_pkg holds:
  - typedef enum logic[1:0] {IDLE, PROCESS, LENET, SWAP_WAIT} seq_state_t;
  - default WIDTH and HEIGHT constants;
  - the ADDR_W=19 constant.
- One natural sub-module, edge_rise: a registered rising-edge detector with synchronous active-high reset, instantiated for cam_vsync and vga_vsync.

Test Plan:
All scenarios use WIDTH=8, HEIGHT=4 (C_FRAME=32) and LENET_TIMEOUT=16.
1. cam_vsync rise at cycle 10 with lenet_signal=0 -> core_en high for cycles 11..42, core_pix_cnt 0..31; after a vga_vsync rise, wr_bank=1, rd_bank=0, frame_cnt=1.
2. lenet_signal pulse during PROCESS; lenet_done 5 cycles after lenet_start -> lenet_start exactly one cycle after the last core_en cycle; lenet_busy held 6 cycles; timeout_err=0; swap on the next vga_vsync rise.
3. lenet_req set, lenet_done never arrives -> timeout_err=1 after 16 LENET cycles; FSM in SWAP_WAIT; timeout_err stays 1 through later frames.
4. Three cam_vsync rises during one PROCESS pass -> exactly one extra pass runs after the swap (cam_pend); frame_cnt increments by 2 in total.
5. rst asserted at core_pix_cnt=17 -> next edge: core_en=0, core_pix_cnt=0, wr_bank=0, rd_bank=1, frame_cnt=0; no pass starts without a new cam_vsync rise.
6. Run 256 frames -> frame_cnt wraps to 0; rd_bank==~wr_bank checked by assertion every cycle.

Source files
------------

// File: rtl/cv_pkg.sv
// cv_pkg: shared types and constants for the camera/vision frame path.
//   seq_state_t   frame sequencer FSM encoding
//   DEF_WIDTH     default pixels per line
//   DEF_HEIGHT    default lines per frame
//   ADDR_W        pixel index width; holds 640*480-1
//   TO_W          LeNet timeout counter width
package cv_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PROCESS   = 2'd1,
    LENET     = 2'd2,
    SWAP_WAIT = 2'd3
  } seq_state_t;

  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;
  localparam int ADDR_W     = 19;
  localparam int TO_W       = 20;

endpackage

// File: rtl/frame_sequencer_if.sv
// frame_sequencer_if: LeNet request/start/done handshake.
//   lenet_signal  request to run LeNet on the next processed frame
//   lenet_done    one-cycle completion pulse from LeNet
//   lenet_start   one-cycle start pulse to LeNet
//   lenet_busy    high while the sequencer waits on LeNet
// master: the sequencer side; slave: the LeNet/requester side.
interface frame_sequencer_if;
  logic lenet_signal;
  logic lenet_done;
  logic lenet_start;
  logic lenet_busy;

  modport master (
    input  lenet_signal,
    input  lenet_done,
    output lenet_start,
    output lenet_busy
  );

  modport slave (
    output lenet_signal,
    output lenet_done,
    input  lenet_start,
    input  lenet_busy
  );
endinterface

// File: rtl/edge_rise.sv
// edge_rise: registered rising-edge detector.
//   clk     clock
//   rst     synchronous active-high reset, clears the history register
//   sig_i   level input, synchronous to clk
//   rise_o  high in the cycle sig_i is first seen high
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= sig_i;
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame controller for the pixel-processing core.
//   clk25         pixel clock
//   rst           synchronous active-high reset
//   cam_vsync     camera frame-complete level (rise = frame ready)
//   vga_vsync     VGA frame-boundary level (rise = safe bank swap)
//   lenet         LeNet handshake (master side)
//   core_en       core pixel enable, C_FRAME cycles per pass
//   core_pix_cnt  current pixel index
//   wr_bank       bank the core writes
//   rd_bank       bank VGA reads, always ~wr_bank
//   frame_cnt     completed-swap counter
//   timeout_err   sticky LeNet timeout flag
//
// state     | meaning
// IDLE      | waiting for a camera frame (new rise or pending one)
// PROCESS   | core enabled, sweeping all pixels of the frame
// LENET     | waiting for LeNet to finish, timeout counter running
// SWAP_WAIT | waiting for a vga_vsync rise to swap output banks
module frame_sequencer
  import cv_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int HEIGHT        = DEF_HEIGHT,
  parameter int LENET_TIMEOUT = 1048576
) (
  input  logic                 clk25,
  input  logic                 rst,
  input  logic                 cam_vsync,
  input  logic                 vga_vsync,
  frame_sequencer_if.master    lenet,
  output logic                 core_en,
  output logic [ADDR_W-1:0]    core_pix_cnt,
  output logic                 wr_bank,
  output logic                 rd_bank,
  output logic [7:0]           frame_cnt,
  output logic                 timeout_err
);

  localparam int C_FRAME = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(C_FRAME - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(LENET_TIMEOUT - 1);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              timeout_err_q, timeout_err_d;
  logic              cam_pend_q, cam_pend_d;
  logic              lenet_req_q, lenet_req_d;
  logic              enter_lenet;
  logic              cam_rise, vga_rise;

  edge_rise u_cam_rise (.clk(clk25), .rst(rst), .sig_i(cam_vsync), .rise_o(cam_rise));
  edge_rise u_vga_rise (.clk(clk25), .rst(rst), .sig_i(vga_vsync), .rise_o(vga_rise));

  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    to_cnt_d      = to_cnt_q;
    wr_bank_d     = wr_bank_q;
    frame_cnt_d   = frame_cnt_q;
    timeout_err_d = timeout_err_q;
    cam_pend_d    = cam_pend_q;
    enter_lenet   = 1'b0;

    // One frame of backlog at most; a rise while already pending is lost.
    if (state_q != IDLE && cam_rise) cam_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (cam_rise || cam_pend_q) begin
          state_d    = PROCESS;
          cam_pend_d = 1'b0;
          pix_cnt_d  = '0;
        end
      end
      PROCESS: begin
        pix_cnt_d = pix_cnt_q + 1'b1;
        if (pix_cnt_q == PIX_LAST) begin
          pix_cnt_d = '0;
          to_cnt_d  = '0;
          if (lenet_req_q) begin
            state_d     = LENET;
            enter_lenet = 1'b1;
          end else begin
            state_d = SWAP_WAIT;
          end
        end
      end
      LENET: begin
        to_cnt_d = to_cnt_q + 1'b1;
        // done takes priority over a coincident timeout
        if (lenet.lenet_done) begin
          state_d = SWAP_WAIT;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = SWAP_WAIT;
        end
      end
      SWAP_WAIT: begin
        if (vga_rise) begin
          wr_bank_d   = ~wr_bank_q;
          frame_cnt_d = frame_cnt_q + 8'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new request arriving as LeNet starts belongs to the next frame.
    lenet_req_d = lenet_req_q;
    if (enter_lenet)        lenet_req_d = 1'b0;
    if (lenet.lenet_signal) lenet_req_d = 1'b1;
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q       <= IDLE;
      pix_cnt_q     <= '0;
      to_cnt_q      <= '0;
      wr_bank_q     <= 1'b0;
      frame_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
      cam_pend_q    <= 1'b0;
      lenet_req_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      to_cnt_q      <= to_cnt_d;
      wr_bank_q     <= wr_bank_d;
      frame_cnt_q   <= frame_cnt_d;
      timeout_err_q <= timeout_err_d;
      cam_pend_q    <= cam_pend_d;
      lenet_req_q   <= lenet_req_d;
    end
  end

  assign core_en           = (state_q == PROCESS);
  assign core_pix_cnt      = pix_cnt_q;
  assign wr_bank           = wr_bank_q;
  assign rd_bank           = ~wr_bank_q;
  assign frame_cnt         = frame_cnt_q;
  assign timeout_err       = timeout_err_q;
  assign lenet.lenet_busy  = (state_q == LENET);
  // The timeout counter is zero only in the first LENET cycle.
  assign lenet.lenet_start = (state_q == LENET) && (to_cnt_q == '0);

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;
  import cv_pkg::*;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int CF = W * H;
  localparam int TO = 16;

  logic        clk25 = 1'b0;
  logic        rst = 1'b1;
  logic        cam_vsync = 1'b0;
  logic        vga_vsync = 1'b0;
  logic        core_en, wr_bank, rd_bank, timeout_err;
  logic [18:0] core_pix_cnt;
  logic [7:0]  frame_cnt;

  frame_sequencer_if lif();

  frame_sequencer #(.WIDTH(W), .HEIGHT(H), .LENET_TIMEOUT(TO)) dut (
    .clk25        (clk25),
    .rst          (rst),
    .cam_vsync    (cam_vsync),
    .vga_vsync    (vga_vsync),
    .lenet        (lif),
    .core_en      (core_en),
    .core_pix_cnt (core_pix_cnt),
    .wr_bank      (wr_bank),
    .rd_bank      (rd_bank),
    .frame_cnt    (frame_cnt),
    .timeout_err  (timeout_err)
  );

  always #5 clk25 = ~clk25;

  typedef struct {
    bit lreq;
    int done_dly;   // LENET cycle index in which done pulses; -1 = never
    int extra;      // extra cam_vsync rises during PROCESS
    bit cam_swap;   // cam_vsync rise in the swap cycle
    int exp_busy;
    bit exp_to;
    int passes;
  } vec_t;

  vec_t vecs[7];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic       wr_model = 1'b0;
  logic [7:0] fc_model = 8'd0;
  logic       to_model = 1'b0;

  task automatic step();
    @(posedge clk25);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk25) begin
    logic exp_rd;
    exp_rd = ~wr_bank;
    check("bank_invariant", {31'b0, rd_bank}, {31'b0, exp_rd});
  end

  task automatic check_swap_state();
    logic exp_rd;
    exp_rd = ~wr_model;
    check("wr_bank", {31'b0, wr_bank}, {31'b0, wr_model});
    check("rd_bank", {31'b0, rd_bank}, {31'b0, exp_rd});
    check("frame_cnt", {24'b0, frame_cnt}, {24'b0, fc_model});
  endtask

  // Entered in the first PROCESS cycle; leaves right after the swap edge.
  task automatic run_pass(input bit lreq, input int done_dly, input int extra,
                          input int exp_busy, input bit exp_to, input bit cam_swap);
    int k;
    for (int i = 0; i < CF; i++) begin
      check("core_en", {31'b0, core_en}, 32'd1);
      check("core_pix_cnt", {13'b0, core_pix_cnt}, i);
      check("busy_in_process", {31'b0, lif.lenet_busy}, 32'd0);
      cam_vsync        = (i >= 1) && (i <= 2 * extra) && ((i % 2) == 1);
      lif.lenet_signal = lreq && (i == 5);
      lif.lenet_done   = (i == 7);
      step();
    end
    cam_vsync        = 1'b0;
    lif.lenet_signal = 1'b0;
    lif.lenet_done   = 1'b0;
    check("core_en_off", {31'b0, core_en}, 32'd0);
    check("core_pix_cnt_ret", {13'b0, core_pix_cnt}, 32'd0);
    k = 0;
    while (lif.lenet_busy && k < 100) begin
      check("lenet_start", {31'b0, lif.lenet_start}, (k == 0) ? 32'd1 : 32'd0);
      lif.lenet_done = (k == done_dly);
      step();
      lif.lenet_done = 1'b0;
      k++;
    end
    check("lenet_busy_cycles", k, exp_busy);
    to_model = to_model | exp_to;
    check("timeout_err", {31'b0, timeout_err}, {31'b0, to_model});
    for (int j = 0; j < 2; j++) begin
      step();
      check("swap_wait_core_en", {31'b0, core_en}, 32'd0);
      check("swap_wait_busy", {31'b0, lif.lenet_busy}, 32'd0);
      check_swap_state();
    end
    cam_vsync = cam_swap;
    vga_vsync = 1'b1;
    step();
    vga_vsync = 1'b0;
    cam_vsync = 1'b0;
    wr_model = ~wr_model;
    fc_model = fc_model + 8'd1;
    check_swap_state();
    check("idle_core_en", {31'b0, core_en}, 32'd0);
  endtask

  task automatic run_vector(input vec_t v);
    cam_vsync = 1'b1;
    step();
    run_pass(v.lreq, v.done_dly, v.extra, v.exp_busy, v.exp_to, v.cam_swap);
    if (v.passes == 2) begin
      step();
      run_pass(1'b0, -1, 0, 0, 1'b0, 1'b0);
    end
    for (int j = 0; j < 3; j++) begin
      step();
      check("no_extra_pass", {31'b0, core_en}, 32'd0);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vecs[0] = '{0, -1, 0, 0,  0, 0, 1};
    vecs[1] = '{1,  5, 0, 0,  6, 0, 1};
    vecs[2] = '{1, 15, 0, 0, 16, 0, 1};
    vecs[3] = '{1,  0, 0, 0,  1, 0, 1};
    vecs[4] = '{1, -1, 0, 0, 16, 1, 1};
    vecs[5] = '{0, -1, 3, 0,  0, 0, 2};
    vecs[6] = '{0, -1, 0, 1,  0, 0, 2};

    lif.lenet_signal = 1'b0;
    lif.lenet_done   = 1'b0;
    rst = 1'b1;
    step();
    step();
    check("rst_core_en", {31'b0, core_en}, 32'd0);
    check("rst_pix_cnt", {13'b0, core_pix_cnt}, 32'd0);
    check("rst_wr_bank", {31'b0, wr_bank}, 32'd0);
    check("rst_rd_bank", {31'b0, rd_bank}, 32'd1);
    check("rst_lenet_start", {31'b0, lif.lenet_start}, 32'd0);
    check("rst_lenet_busy", {31'b0, lif.lenet_busy}, 32'd0);
    check("rst_frame_cnt", {24'b0, frame_cnt}, 32'd0);
    check("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
    rst = 1'b0;
    while (cyc < 9) begin
      step();
      check("idle_before_frame", {31'b0, core_en}, 32'd0);
    end

    // Vector 0 starts with the cam_vsync rise sampled at cycle 10.
    for (int n = 0; n < 7; n++) run_vector(vecs[n]);

    // Reset in the middle of a pass.
    cam_vsync = 1'b1;
    step();
    cam_vsync = 1'b0;
    k = 0;
    while (core_pix_cnt != 19'd17 && k < 100) begin
      step();
      k++;
    end
    check("reach_pix_17", {13'b0, core_pix_cnt}, 32'd17);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wr_model = 1'b0;
    fc_model = 8'd0;
    to_model = 1'b0;
    check("midrst_core_en", {31'b0, core_en}, 32'd0);
    check("midrst_pix_cnt", {13'b0, core_pix_cnt}, 32'd0);
    check("midrst_timeout_err", {31'b0, timeout_err}, 32'd0);
    check_swap_state();
    for (int j = 0; j < 10; j++) begin
      step();
      check("midrst_no_restart", {31'b0, core_en}, 32'd0);
    end

    // 256 frames: frame_cnt wraps back to 0, banks back to the reset pairing.
    for (int n = 0; n < 256; n++) run_vector(vecs[0]);
    check("wrap_frame_cnt", {24'b0, frame_cnt}, 32'd0);
    check("wrap_wr_bank", {31'b0, wr_bank}, 32'd0);
    check("wrap_rd_bank", {31'b0, rd_bank}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
